// File: rtl/minmax_pkg.sv
// rtl/minmax_pkg.sv - shared types for the min/max frame reducer
package minmax_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } minmax_state_e;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/cmp_sel_u32.sv
// rtl/cmp_sel_u32.sv - combinational unsigned compare-select, incumbent a wins ties
module cmp_sel_u32 #(
    parameter int W = minmax_pkg::DATA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel_max,
    output logic [W-1:0] y,
    output logic         b_wins
);

    assign b_wins = sel_max ? (b > a) : (b < a);
    assign y      = b_wins ? b : a;

endmodule

// File: rtl/minmax_frame_reducer.sv
// rtl/minmax_frame_reducer.sv - folds each framed word stream to its max or min
// Optional out_idx port and winner index register under MINMAX_ARGIDX_EN.
module minmax_frame_reducer #(
    parameter int DATA_W = minmax_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_max,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat
`ifdef MINMAX_ARGIDX_EN
    ,
    output logic [CNT_W-1:0]  out_idx
`endif
);

    import minmax_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    minmax_state_e     state;
    minmax_state_e     state_nxt;
    logic              mode_r;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] cmp_y;
    logic              b_wins;
    logic              accept;

    assign accept = in_valid & in_ready;

    cmp_sel_u32 #(
        .W(DATA_W)
    ) u_cmp (
        .a      (acc),
        .b      (in_data),
        .sel_max(mode_r),
        .y      (cmp_y),
        .b_wins (b_wins)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state != HOLD);
        out_valid = (state == HOLD);
        case (state)
            IDLE, ACCUM: begin
                if (in_valid) begin
                    state_nxt = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The accumulator doubles as the result register: it cannot move while in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            mode_r <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                acc    <= in_data;
                mode_r <= mode_max;
                cnt    <= CNT_ONE;
            end else begin
                acc <= cmp_y;
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end
    end

    assign out_data  = acc;
    assign out_count = cnt;
    assign out_sat   = (cnt == CNT_MAX);

`ifdef MINMAX_ARGIDX_EN
    logic [CNT_W-1:0] idx;

    // Pre-increment count is the incoming beat's position, already saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                idx <= '0;
            end else if (b_wins) begin
                idx <= cnt;
            end
        end
    end

    assign out_idx = idx;
`endif

endmodule

// File: tb/tb_minmax_frame_reducer.sv
// tb/tb_minmax_frame_reducer.sv - scoreboard bench for minmax_frame_reducer
module tb_minmax_frame_reducer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode_max, in_valid, in_ready, in_last;
    logic        out_valid, out_ready, out_sat;
    logic [31:0] in_data, out_data;
    logic [15:0] out_count;

    logic        s_mode_max, s_in_valid, s_in_ready, s_in_last;
    logic        s_out_valid, s_out_ready, s_out_sat;
    logic [31:0] s_in_data, s_out_data;
    logic [3:0]  s_out_count;
`ifdef MINMAX_ARGIDX_EN
    logic [15:0] out_idx;
    logic [3:0]  s_out_idx;
`endif

    always #5 clk = ~clk;

    minmax_frame_reducer #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .mode_max(mode_max),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_sat(out_sat)
`ifdef MINMAX_ARGIDX_EN
        , .out_idx(out_idx)
`endif
    );

    minmax_frame_reducer #(.DATA_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .mode_max(s_mode_max),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_count(s_out_count), .out_sat(s_out_sat)
`ifdef MINMAX_ARGIDX_EN
        , .out_idx(s_out_idx)
`endif
    );

    typedef struct {
        logic [31:0] d;
        logic [31:0] c;
        logic        s;
        logic [31:0] i;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] fd[0:31];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int n, input logic mode, input int cmax);
        exp_t e;
        e.d = fd[0];
        e.i = 0;
        for (int k = 1; k < n; k++) begin
            if (mode ? (fd[k] > e.d) : (fd[k] < e.d)) begin
                e.d = fd[k];
                e.i = (k > cmax) ? cmax : k;
            end
        end
        e.c = (n > cmax) ? cmax : n;
        e.s = (n >= cmax);
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_count", {16'd0, out_count}, e.c);
                chk("out_sat", {31'd0, out_sat}, {31'd0, e.s});
`ifdef MINMAX_ARGIDX_EN
                chk("out_idx", {16'd0, out_idx}, e.i);
`endif
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic last, input logic mode);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        mode_max = mode;
        do begin
            @(negedge clk);
            guard++;
        end while (!in_ready && guard < 200);
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Mode is flipped after the first beat to show mid-frame changes are ignored.
    task automatic send_frame(input int n, input logic mode, input bit gap);
        sb.push_back(model(n, mode, 65535));
        for (int k = 0; k < n; k++) begin
            send_beat(fd[k], k == n - 1, (k == 0) ? mode : ~mode);
            if (gap && k < n - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid = 0; in_data = 0; in_last = 0; mode_max = 0; out_ready = 1;
        s_in_valid = 0; s_in_data = 0; s_in_last = 0; s_mode_max = 0; s_out_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_count", {16'd0, out_count}, 32'd0);
        chk("rst_out_sat", {31'd0, out_sat}, 32'd0);
        @(posedge clk);
        #1;

        fd[0] = 5; fd[1] = 9; fd[2] = 3; fd[3] = 9; fd[4] = 1;
        send_frame(5, 1'b1, 1'b0);
        @(negedge clk);
        chk("t1_latency", {31'd0, out_valid}, 32'd1);
        wait_drain();

        fd[0] = 32'hFFFF_FFFF; fd[1] = 32'h8000_0000; fd[2] = 32'h7FFF_FFFF;
        send_frame(3, 1'b0, 1'b1);
        wait_drain();

        out_ready = 1'b0;
        fd[0] = 32'h1234;
        send_frame(1, 1'b1, 1'b0);
        @(negedge clk);
        chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_count", {16'd0, out_count}, 32'd1);
        repeat (3) begin
            chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain();

        out_ready = 1'b0;
        fd[0] = 100; fd[1] = 300; fd[2] = 200;
        send_frame(3, 1'b1, 1'b0);
        in_valid = 1'b1; in_data = 32'h55; in_last = 1'b0; mode_max = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
            chk("t4_out_valid", {31'd0, out_valid}, 32'd1);
            chk("t4_hold_data", out_data, 32'd300);
            chk("t4_hold_count", {16'd0, out_count}, 32'd3);
        end
        fd[0] = 32'h55; fd[1] = 32'h44;
        sb.push_back(model(2, 1'b0, 65535));
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_ready_after_hs", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        send_beat(32'h44, 1'b1, 1'b1);
        wait_drain();

        send_beat(1000, 1'b0, 1'b1);
        send_beat(2000, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t5_count", {16'd0, out_count}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        fd[0] = 50; fd[1] = 70;
        send_frame(2, 1'b0, 1'b0);
        wait_drain();

        for (int k = 0; k < 20; k++) begin
            s_in_valid = 1'b1;
            s_in_data  = (k == 16) ? 32'd1000 : 32'(k * 3 + 1);
            s_in_last  = (k == 19);
            s_mode_max = (k == 0);
            @(negedge clk);
            chk("t6_in_ready", {31'd0, s_in_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", {31'd0, s_out_valid}, 32'd1);
        chk("t6_out_data", s_out_data, 32'd1000);
        chk("t6_out_count", {28'd0, s_out_count}, 32'd15);
        chk("t6_out_sat", {31'd0, s_out_sat}, 32'd1);
`ifdef MINMAX_ARGIDX_EN
        chk("t6_out_idx", {28'd0, s_out_idx}, 32'd15);
`endif
        @(posedge clk);
        #1 s_out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_released", {31'd0, s_out_valid}, 32'd0);

        wait_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
